// File: rtl/stepper_pkg.sv
// Shared definitions for the STEP/DIR pulse generator: FSM states,
// default driver timing and direction encoding.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIR_WAIT  = 2'd1,
        STEP_HIGH = 2'd2,
        STEP_LOW  = 2'd3
    } step_state_t;

    // Default driver timing in clk cycles (50 MHz clock)
    localparam int PULSE_HIGH_DEF = 100;  // 2 us step high, also minimum low time
    localparam int DIR_SETUP_DEF  = 250;  // 5 us DIR setup before a STEP rise
    localparam int MIN_PERIOD_DEF = 200;  // minimum rise-to-rise interval

    // DIR pin encoding
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/step_interval_counter.sv
// Loadable down-counter timing the step-high, step-low and dir-setup
// intervals. A value L loaded on one edge raises done during the L-th
// following cycle, so the consumer switches state exactly L edges later.
module step_interval_counter #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = tick && (count == WIDTH'(1));

endmodule

// File: rtl/step_pulse_gen.sv
// STEP/DIR pulse generator between the tracking controller and the
// stepper driver IC. Guarantees step high/low widths, DIR setup before
// a rise and a minimum rise-to-rise period; keeps a signed step count.
module step_pulse_gen
    import stepper_pkg::*;
#(
    parameter int WIDTH_WORK = 16,
    parameter int WIDTH_POS  = 32,
    parameter int PRESCALE   = 1,
    parameter int PULSE_HIGH = PULSE_HIGH_DEF,
    parameter int DIR_SETUP  = DIR_SETUP_DEF,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  dir,
    input  logic [WIDTH_WORK-1:0] period,
    input  logic                  period_valid,
    input  logic                  pos_clear,
    output logic                  step,
    output logic                  dir_out,
    output logic                  busy,
    output logic [WIDTH_POS-1:0]  position
);

    // Product wide enough that period*PRESCALE never truncates
    localparam int PROD_W = WIDTH_WORK + $clog2(PRESCALE) + 1;
    // Interval counter must hold the longest of eff_period and DIR_SETUP
    localparam int CNT_W  = max_int(PROD_W,
                                    max_int($clog2(DIR_SETUP + 1), $clog2(MIN_PERIOD + 1)));

    step_state_t           state;
    logic [WIDTH_WORK-1:0] period_shadow;
    logic [PROD_W-1:0]     period_prod;
    logic [CNT_W-1:0]      prod_ext;
    logic [CNT_W-1:0]      eff_period;
    logic [CNT_W-1:0]      lat_period;
    logic [CNT_W-1:0]      low_thresh;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_load_val;
    logic                  cnt_load;
    logic                  cnt_done;
    logic                  go_ok;
    logic                  at_boundary;
    logic                  take_rise;
    logic                  take_dirwait;
    logic                  end_high;
    logic                  low_min_met;

    // All intervals are counted in clk cycles; the period is pre-scaled
    // by the multiply, so the counter advances every cycle.
    step_interval_counter #(
        .WIDTH (CNT_W)
    ) u_interval (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (1'b1),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .count    (cnt),
        .done     (cnt_done)
    );

    // Capture the requested period; it only takes effect at a step boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_shadow <= '0;
        end else if (period_valid) begin
            period_shadow <= period;
        end
    end

    // Boundary decision, interval reload selection and low-time check
    always_comb begin
        period_prod  = PROD_W'(period_shadow) * PROD_W'(PRESCALE);
        prod_ext     = CNT_W'(period_prod);
        eff_period   = (prod_ext < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : prod_ext;

        go_ok        = enable && (period_shadow != '0);
        at_boundary  = (state == IDLE) || ((state == STEP_LOW) && cnt_done);
        take_rise    = (at_boundary && go_ok && (dir == dir_out))
                     || ((state == DIR_WAIT) && enable && cnt_done);
        take_dirwait = at_boundary && go_ok && (dir != dir_out);
        end_high     = (state == STEP_HIGH) && cnt_done;

        // Low time reaches PULSE_HIGH when the remaining low count has
        // dropped to lat_period - 2*PULSE_HIGH + 1
        low_thresh   = lat_period - CNT_W'(2 * PULSE_HIGH) + CNT_W'(1);
        low_min_met  = (cnt <= low_thresh);

        cnt_load     = take_rise || take_dirwait || end_high;
        if (take_rise) begin
            cnt_load_val = CNT_W'(PULSE_HIGH);
        end else if (take_dirwait) begin
            cnt_load_val = CNT_W'(DIR_SETUP);
        end else begin
            cnt_load_val = lat_period - CNT_W'(PULSE_HIGH);
        end
    end

    // Step sequencing FSM with registered STEP/DIR pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= 1'b0;
            dir_out    <= DIR_DOWN;
            lat_period <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_rise) begin
                        state      <= STEP_HIGH;
                        step       <= 1'b1;
                        lat_period <= eff_period;
                    end else if (take_dirwait) begin
                        state      <= DIR_WAIT;
                        dir_out    <= dir;
                        lat_period <= eff_period;
                    end
                end
                DIR_WAIT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (cnt_done) begin
                        state <= STEP_HIGH;
                        step  <= 1'b1;
                    end
                end
                STEP_HIGH: begin
                    if (end_high) begin
                        state <= STEP_LOW;
                        step  <= 1'b0;
                    end
                end
                STEP_LOW: begin
                    if (cnt_done) begin
                        if (take_rise) begin
                            state      <= STEP_HIGH;
                            step       <= 1'b1;
                            lat_period <= eff_period;
                        end else if (take_dirwait) begin
                            state      <= DIR_WAIT;
                            dir_out    <= dir;
                            lat_period <= eff_period;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!enable && low_min_met) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Signed step count; a clear wins over a coincident step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position <= '0;
        end else if (pos_clear) begin
            position <= '0;
        end else if (take_rise) begin
            if (dir_out == DIR_UP) begin
                position <= position + WIDTH_POS'(1);
            end else begin
                position <= position - WIDTH_POS'(1);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
